// File: rtl/ornek_acc_sched_pkg.sv
// Shared constants for the two-requester accumulator scheduler.
package ornek_acc_sched_pkg;

  // Default widths, matching the accumulating datapath's datain/dataout
  localparam int DATA_W_DEF = 8;
  localparam int RES_W_DEF  = 10;

  // FSM encoding
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  // Requester ids, used as bit positions in req/gnt/advance vectors.
  // prio uses the same numbering: 0 = A first, 1 = B first.
  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

endpackage

// File: rtl/ornek_acc_sched_rr_prio_2.sv
// Two-way round-robin pick plus priority rotation after a released grant.
module ornek_acc_sched_rr_prio_2
  import ornek_acc_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  input  logic [1:0] advance,
  output logic [1:0] gnt,
  output logic       prio_nxt
);

  // Grant the priority side on contention; hand priority to the side that
  // did not just release the datapath.
  always_comb begin
    gnt = '0;
    if (req[REQ_A] && (!req[REQ_B] || !prio)) gnt[REQ_A] = 1'b1;
    else if (req[REQ_B])                      gnt[REQ_B] = 1'b1;
    prio_nxt = prio;
    if (advance[REQ_A])      prio_nxt = 1'b1;
    else if (advance[REQ_B]) prio_nxt = 1'b0;
  end

endmodule

// File: rtl/ornek_acc_sched.sv
// Round-robin scheduler giving one requester the accumulating datapath
// for a whole accumulation, with result routing and a beat watchdog.
module ornek_acc_sched
  import ornek_acc_sched_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RES_W     = RES_W_DEF,
  parameter int MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              acc_valid_o,
  output logic [DATA_W-1:0] acc_data_o,
  input  logic              acc_ready_i,
  input  logic              acc_done_i,
  input  logic [RES_W-1:0]  acc_result_i,
  output logic              a_done_o,
  output logic [RES_W-1:0]  a_result_o,
  output logic              b_done_o,
  output logic [RES_W-1:0]  b_result_o,
  output logic              err_o
);

  localparam int               CNT_W   = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic [1:0]       state;
  logic             prio, prio_nxt;
  logic [CNT_W-1:0] beat_cnt, cnt_nxt;
  logic             own_a, own_b, fire, wd_hit;
  logic [1:0]       gnt, rel;
  beat_t            sel;

  assign own_a = (state == OWN_A);
  assign own_b = (state == OWN_B);

  // Owner's beat goes straight through; nothing is forwarded while idle.
  always_comb begin
    sel = '0;
    if (own_a)      sel = '{valid: a_valid_i, data: a_data_i};
    else if (own_b) sel = '{valid: b_valid_i, data: b_data_i};
  end

  assign acc_valid_o = sel.valid;
  assign acc_data_o  = sel.data;
  assign a_ready_o   = own_a & a_valid_i & acc_ready_i;
  assign b_ready_o   = own_b & b_valid_i & acc_ready_i;
  assign fire        = sel.valid & acc_ready_i;

  // Saturating beat count; a done in the same cycle overrides the watchdog.
  assign cnt_nxt = (fire && beat_cnt != CNT_MAX) ? beat_cnt + CNT_W'(1) : beat_cnt;
  assign wd_hit  = (own_a | own_b) & (cnt_nxt == CNT_MAX) & ~acc_done_i;
  assign rel     = {own_b & (acc_done_i | wd_hit), own_a & (acc_done_i | wd_hit)};

  ornek_acc_sched_rr_prio_2 u_rr (
    .req      ({b_valid_i, a_valid_i}),
    .prio     (prio),
    .advance  (rel),
    .gnt      (gnt),
    .prio_nxt (prio_nxt)
  );

  // Grant FSM, result capture and single-cycle done/err pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      prio       <= 1'b0;
      beat_cnt   <= '0;
      a_done_o   <= 1'b0;
      b_done_o   <= 1'b0;
      err_o      <= 1'b0;
      a_result_o <= '0;
      b_result_o <= '0;
    end else begin
      a_done_o <= 1'b0;
      b_done_o <= 1'b0;
      err_o    <= 1'b0;
      prio     <= prio_nxt;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          // A done with no owner is discarded; hold off granting that cycle.
          if (acc_done_i)        err_o <= 1'b1;
          else if (gnt[REQ_A])   state <= OWN_A;
          else if (gnt[REQ_B])   state <= OWN_B;
        end
        OWN_A, OWN_B: begin
          if (acc_done_i) begin
            state    <= IDLE;
            beat_cnt <= '0;
            if (own_a) begin
              a_result_o <= acc_result_i;
              a_done_o   <= 1'b1;
            end else begin
              b_result_o <= acc_result_i;
              b_done_o   <= 1'b1;
            end
          end else if (wd_hit) begin
            state    <= IDLE;
            beat_cnt <= '0;
            err_o    <= 1'b1;
          end else begin
            beat_cnt <= cnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ornek_acc_sched.sv
// Bench for ornek_acc_sched: behavioural accumulator (ready=1, done when
// sum >= 60, result = sum) behind two scheduler instances, one with a
// roomy watchdog and one with MAX_BEATS=4.
module tb_ornek_acc_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, acc_ready, force_done;
  logic [9:0] force_res;

  logic       a_valid, b_valid, a_ready, b_ready, acc_valid, acc_done, a_done, b_done, err;
  logic [7:0] a_data, b_data, acc_data;
  logic [9:0] acc_result, a_result, b_result;

  logic       w_a_valid, w_b_valid, w_a_ready, w_b_ready, w_acc_valid, w_acc_done, w_a_done, w_b_done, w_err;
  logic [7:0] w_a_data, w_b_data, w_acc_data;
  logic [9:0] w_acc_result, w_a_result, w_b_result;

  logic [15:0] sum, w_sum;

  ornek_acc_sched #(.MAX_BEATS(32)) dut (
    .clk(clk), .rst(rst),
    .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_ready),
    .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(b_ready),
    .acc_valid_o(acc_valid), .acc_data_o(acc_data), .acc_ready_i(acc_ready),
    .acc_done_i(acc_done), .acc_result_i(acc_result),
    .a_done_o(a_done), .a_result_o(a_result),
    .b_done_o(b_done), .b_result_o(b_result), .err_o(err)
  );

  ornek_acc_sched #(.MAX_BEATS(4)) dut_wd (
    .clk(clk), .rst(rst),
    .a_valid_i(w_a_valid), .a_data_i(w_a_data), .a_ready_o(w_a_ready),
    .b_valid_i(w_b_valid), .b_data_i(w_b_data), .b_ready_o(w_b_ready),
    .acc_valid_o(w_acc_valid), .acc_data_o(w_acc_data), .acc_ready_i(acc_ready),
    .acc_done_i(w_acc_done), .acc_result_i(w_acc_result),
    .a_done_o(w_a_done), .a_result_o(w_a_result),
    .b_done_o(w_b_done), .b_result_o(w_b_result), .err_o(w_err)
  );

  // Behavioural accumulators: done in the same cycle as the beat that reaches 60
  always_comb begin
    acc_done   = force_done;
    acc_result = force_res;
    if (!force_done && acc_valid && acc_ready && (sum + 16'(acc_data)) >= 16'd60) begin
      acc_done   = 1'b1;
      acc_result = 10'(sum + 16'(acc_data));
    end
    w_acc_done   = 1'b0;
    w_acc_result = 10'(w_sum + 16'(w_acc_data));
    if (w_acc_valid && acc_ready && (w_sum + 16'(w_acc_data)) >= 16'd60) w_acc_done = 1'b1;
  end

  always @(posedge clk) begin
    if (!rst)                         sum <= '0;
    else if (acc_done)                sum <= '0;
    else if (acc_valid && acc_ready)  sum <= sum + 16'(acc_data);
    if (!rst)                         w_sum <= '0;
    else if (w_acc_done)              w_sum <= '0;
    else if (w_acc_valid && acc_ready) w_sum <= w_sum + 16'(w_acc_data);
  end

  int checks, errors;
  logic [7:0] a_beats[$], b_beats[$], w_a_beats[$], w_b_beats[$];
  logic [9:0] exp_a[$], exp_b[$], w_exp_a[$], w_exp_b[$];
  int err_exp, w_err_exp, a_fires;
  bit glog[$], wglog[$];
  bit in_grant, w_in_grant;

  function automatic string log_str(input bit q[$]);
    string s = "";
    foreach (q[i]) s = {s, q[i] ? "B" : "A"};
    return s;
  endfunction

  function automatic bit busy();
    return (a_beats.size() + b_beats.size() + w_a_beats.size() + w_b_beats.size() +
            exp_a.size() + exp_b.size() + w_exp_a.size() + w_exp_b.size()) != 0 ||
           err_exp != 0 || w_err_exp != 0;
  endfunction

  task automatic drive();
    a_valid   = a_beats.size() != 0;   a_data   = a_valid   ? a_beats[0]   : 8'd0;
    b_valid   = b_beats.size() != 0;   b_data   = b_valid   ? b_beats[0]   : 8'd0;
    w_a_valid = w_a_beats.size() != 0; w_a_data = w_a_valid ? w_a_beats[0] : 8'd0;
    w_b_valid = w_b_beats.size() != 0; w_b_data = w_b_valid ? w_b_beats[0] : 8'd0;
  endtask

  // One clock: sample at negedge, score done/err pulses, advance beat queues
  task automatic tick();
    logic [9:0] e;
    bit af, bf, waf, wbf;
    @(negedge clk);
    if (a_done) begin
      checks++;
      if (exp_a.size() == 0) begin errors++; $display("FAIL a_done unexpected: result %0d, none expected", a_result); end
      else begin e = exp_a.pop_front();
        if (a_result !== e) begin errors++; $display("FAIL a_result: got %0d exp %0d", a_result, e); end end
    end
    if (b_done) begin
      checks++;
      if (exp_b.size() == 0) begin errors++; $display("FAIL b_done unexpected: result %0d, none expected", b_result); end
      else begin e = exp_b.pop_front();
        if (b_result !== e) begin errors++; $display("FAIL b_result: got %0d exp %0d", b_result, e); end end
    end
    if (w_a_done) begin
      checks++;
      if (w_exp_a.size() == 0) begin errors++; $display("FAIL wd a_done unexpected: result %0d, none expected", w_a_result); end
      else begin e = w_exp_a.pop_front();
        if (w_a_result !== e) begin errors++; $display("FAIL wd a_result: got %0d exp %0d", w_a_result, e); end end
    end
    if (w_b_done) begin
      checks++;
      if (w_exp_b.size() == 0) begin errors++; $display("FAIL wd b_done unexpected: result %0d, none expected", w_b_result); end
      else begin e = w_exp_b.pop_front();
        if (w_b_result !== e) begin errors++; $display("FAIL wd b_result: got %0d exp %0d", w_b_result, e); end end
    end
    if (err) begin
      checks++;
      if (err_exp == 0) begin errors++; $display("FAIL err unexpected: got 1 exp 0"); end
      else err_exp--;
    end
    if (w_err) begin
      checks++;
      if (w_err_exp == 0) begin errors++; $display("FAIL wd err unexpected: got 1 exp 0"); end
      else w_err_exp--;
    end
    if (a_ready || b_ready) begin
      checks++;
      if (a_ready && b_ready) begin errors++; $display("FAIL ready exclusive: got a=1 b=1 exp one side only"); end
    end
    af  = a_valid && a_ready;      bf  = b_valid && b_ready;
    waf = w_a_valid && w_a_ready;  wbf = w_b_valid && w_b_ready;
    if (a_done || b_done || err)       in_grant   = 1'b0;
    if (w_a_done || w_b_done || w_err) w_in_grant = 1'b0;
    if ((af || bf) && !in_grant)     begin glog.push_back(bf);   in_grant   = 1'b1; end
    if ((waf || wbf) && !w_in_grant) begin wglog.push_back(wbf); w_in_grant = 1'b1; end
    @(posedge clk); #1;
    if (af)  begin void'(a_beats.pop_front()); a_fires++; end
    if (bf)  void'(b_beats.pop_front());
    if (waf) void'(w_a_beats.pop_front());
    if (wbf) void'(w_b_beats.pop_front());
    drive();
  endtask

  task automatic run(input string name, input int max);
    int n = 0;
    while (busy() && n < max) begin tick(); n++; end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL %s timeout: got pending work after %0d cycles exp drained", name, max);
      a_beats.delete(); b_beats.delete(); w_a_beats.delete(); w_b_beats.delete();
      exp_a.delete(); exp_b.delete(); w_exp_a.delete(); w_exp_b.delete();
      err_exp = 0; w_err_exp = 0; drive();
    end
    repeat (3) tick();
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    a_beats.delete(); b_beats.delete(); w_a_beats.delete(); w_b_beats.delete();
    drive();
    tick();
    rst = 1'b1;
    in_grant = 1'b0; w_in_grant = 1'b0;
    glog.delete(); wglog.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; drive();
    tick(); tick();
    checks += 9;
    if (a_ready !== 1'b0)   begin errors++; $display("FAIL reset a_ready: got %b exp 0", a_ready); end
    if (b_ready !== 1'b0)   begin errors++; $display("FAIL reset b_ready: got %b exp 0", b_ready); end
    if (acc_valid !== 1'b0) begin errors++; $display("FAIL reset acc_valid: got %b exp 0", acc_valid); end
    if (acc_data !== 8'd0)  begin errors++; $display("FAIL reset acc_data: got %0d exp 0", acc_data); end
    if (a_done !== 1'b0)    begin errors++; $display("FAIL reset a_done: got %b exp 0", a_done); end
    if (b_done !== 1'b0)    begin errors++; $display("FAIL reset b_done: got %b exp 0", b_done); end
    if (err !== 1'b0)       begin errors++; $display("FAIL reset err: got %b exp 0", err); end
    if (a_result !== 10'd0) begin errors++; $display("FAIL reset a_result: got %0d exp 0", a_result); end
    if (b_result !== 10'd0) begin errors++; $display("FAIL reset b_result: got %0d exp 0", b_result); end
  endtask

  task automatic test_both_from_reset();
    a_beats = '{8'd15, 8'd20, 8'd25}; b_beats = '{8'd30, 8'd30};
    exp_a.push_back(10'd60); exp_b.push_back(10'd60);
    drive(); tick();
    rst = 1'b1;
    run("both_from_reset", 60);
    checks++;
    if (log_str(glog) != "AB") begin errors++; $display("FAIL both_from_reset order: got %s exp AB", log_str(glog)); end
  endtask

  task automatic test_a_alone();
    glog.delete(); a_fires = 0;
    a_beats = '{8'd15, 8'd20, 8'd25}; exp_a.push_back(10'd60);
    drive();
    run("a_alone", 60);
    checks += 3;
    if (a_fires != 3)       begin errors++; $display("FAIL a_alone beats: got %0d exp 3", a_fires); end
    if (b_result !== 10'd60) begin errors++; $display("FAIL a_alone b_result held: got %0d exp 60", b_result); end
    if (log_str(glog) != "A") begin errors++; $display("FAIL a_alone order: got %s exp A", log_str(glog)); end
  endtask

  task automatic test_prio_rotation();
    glog.delete();
    a_beats = '{8'd60}; b_beats = '{8'd60};
    exp_a.push_back(10'd60); exp_b.push_back(10'd60);
    drive();
    run("prio_rotation", 40);
    checks++;
    if (log_str(glog) != "BA") begin errors++; $display("FAIL prio_rotation order: got %s exp BA", log_str(glog)); end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int r = 0; r < 20; r++) for (int k = 1; k <= 3; k++) a_beats.push_back(8'(k));
    repeat (6) b_beats.push_back(8'd20);
    repeat (2) begin exp_a.push_back(10'd60); exp_b.push_back(10'd60); end
    drive();
    run("fairness", 300);
    checks++;
    if (log_str(glog) != "ABAB") begin errors++; $display("FAIL fairness order: got %s exp ABAB", log_str(glog)); end
  endtask

  task automatic test_done_idle();
    force_done = 1'b1; force_res = 10'd99; err_exp = 1;
    tick();
    force_done = 1'b0;
    run("done_idle", 10);
    checks += 2;
    if (a_result !== 10'd60) begin errors++; $display("FAIL done_idle a_result: got %0d exp 60", a_result); end
    if (b_result !== 10'd60) begin errors++; $display("FAIL done_idle b_result: got %0d exp 60", b_result); end
  endtask

  task automatic test_reset_mid();
    a_beats = '{8'd60}; exp_a.push_back(10'd60); drive();
    run("reset_mid_setup", 20);
    glog.delete(); a_fires = 0;
    a_beats = '{8'd15, 8'd20, 8'd25}; drive();
    for (int n = 0; n < 20 && a_fires < 1; n++) tick();
    checks++;
    if (a_fires != 1) begin errors++; $display("FAIL reset_mid first beat: got %0d beats exp 1", a_fires); end
    rst = 1'b0;
    tick();
    a_beats.delete(); drive();
    rst = 1'b1; in_grant = 1'b0; glog.delete();
    checks += 5;
    if (a_ready !== 1'b0)   begin errors++; $display("FAIL reset_mid a_ready: got %b exp 0", a_ready); end
    if (acc_valid !== 1'b0) begin errors++; $display("FAIL reset_mid acc_valid: got %b exp 0", acc_valid); end
    if (a_result !== 10'd0) begin errors++; $display("FAIL reset_mid a_result: got %0d exp 0", a_result); end
    if (b_result !== 10'd0) begin errors++; $display("FAIL reset_mid b_result: got %0d exp 0", b_result); end
    if (err !== 1'b0)       begin errors++; $display("FAIL reset_mid err: got %b exp 0", err); end
    a_beats = '{8'd15, 8'd20, 8'd25}; b_beats = '{8'd60};
    exp_a.push_back(10'd60); exp_b.push_back(10'd60);
    drive();
    run("reset_mid_fresh", 60);
    checks++;
    if (log_str(glog) != "AB") begin errors++; $display("FAIL reset_mid order: got %s exp AB", log_str(glog)); end
  endtask

  task automatic test_watchdog();
    wglog.delete();
    w_a_beats = '{8'd1, 8'd1, 8'd1, 8'd1}; w_err_exp = 1;
    drive();
    run("watchdog_abort", 30);
    checks += 2;
    if (w_a_result !== 10'd0) begin errors++; $display("FAIL watchdog a_result: got %0d exp 0", w_a_result); end
    if (log_str(wglog) != "A") begin errors++; $display("FAIL watchdog first grant: got %s exp A", log_str(wglog)); end
    // datapath still holds 4 from the aborted run
    w_b_beats = '{8'd56}; w_a_beats = '{8'd60};
    w_exp_b.push_back(10'd60); w_exp_a.push_back(10'd60);
    drive();
    run("watchdog_next", 40);
    checks++;
    if (log_str(wglog) != "ABA") begin errors++; $display("FAIL watchdog regrant order: got %s exp ABA", log_str(wglog)); end
  endtask

  initial begin
    checks = 0; errors = 0; err_exp = 0; w_err_exp = 0; a_fires = 0;
    in_grant = 1'b0; w_in_grant = 1'b0;
    rst = 1'b0; acc_ready = 1'b1; force_done = 1'b0; force_res = '0;
    drive();
    test_reset();
    test_both_from_reset();
    test_a_alone();
    test_prio_rotation();
    test_fairness();
    test_done_idle();
    test_reset_mid();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
